// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 prefix codes and state encodings for the scan receiver.
package ps2_pkg;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
    typedef enum logic [1:0] {D_NORMAL, D_BREAK, D_EXT, D_EXT_BREAK} dec_state_t;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer, FILTER_LEN-sample glitch filter and falling-edge strobe.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic s1, s2, flip;
    logic [CW-1:0] cnt;
    assign flip = s2 != level && cnt == CW'(FILTER_LEN - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            s1    <= line;
            s2    <= s1;
            cnt   <= (s2 == level || flip) ? '0 : cnt + 1'b1;
            level <= flip ? s2 : level;
            fall  <= flip && level;
        end
    end
endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: deframes PS/2 set-2 frames and holds the make code of the pressed key.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       key_released,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    frame_state_t fstate, fstate_n;
    dec_state_t dstate, dstate_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n, code_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic fall, clk_level, data_s1, data_s;
    logic par, par_n, byte_ok, timeout, sv_n, kr_n, err_n, is_prefix;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk  (clk),
        .rst_n(rst_n),
        .line (ps2_clk),
        .level(clk_level),
        .fall (fall)
    );

    always_comb begin
        fstate_n  = fstate;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par;
        byte_ok   = 1'b0;
        err_n     = 1'b0;
        timeout   = fstate != F_IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES);
        tcnt_n    = (fstate == F_IDLE || fall || timeout) ? '0 : tcnt + 1'b1;
        if (timeout) begin
            fstate_n = F_IDLE;
            err_n    = 1'b1;
        end else if (fall) begin
            case (fstate)
                F_IDLE: begin
                    fstate_n  = data_s ? F_IDLE : F_DATA;
                    bit_cnt_n = '0;
                end
                F_DATA: begin
                    shreg_n   = {data_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    fstate_n  = bit_cnt == 3'd7 ? F_PARITY : F_DATA;
                end
                F_PARITY: begin
                    par_n    = data_s;
                    fstate_n = F_STOP;
                end
                default: begin
                    byte_ok  = data_s && ^{shreg, par};
                    err_n    = !byte_ok;
                    fstate_n = F_IDLE;
                end
            endcase
        end
    end

    // The decoder consumes the byte on the stop-bit strobe; its outputs land one clk later.
    assign is_prefix = shreg == PS2_EXT || shreg == PS2_BREAK;
    always_comb begin
        dstate_n = dstate;
        code_n   = scan_code;
        sv_n     = 1'b0;
        kr_n     = 1'b0;
        if (err_n) begin
            dstate_n = D_NORMAL;
        end else if (byte_ok) begin
            case (dstate)
                D_NORMAL: begin
                    dstate_n = shreg == PS2_EXT ? D_EXT : shreg == PS2_BREAK ? D_BREAK : D_NORMAL;
                    sv_n     = !is_prefix;
                    code_n   = is_prefix ? scan_code : shreg;
                end
                D_BREAK: begin
                    dstate_n = D_NORMAL;
                    kr_n     = shreg == scan_code;
                    code_n   = shreg == scan_code ? 8'h00 : scan_code;
                end
                D_EXT:   dstate_n = shreg == PS2_BREAK ? D_EXT_BREAK : D_NORMAL;
                default: dstate_n = D_NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_s1      <= 1'b1;
            data_s       <= 1'b1;
            fstate       <= F_IDLE;
            dstate       <= D_NORMAL;
            bit_cnt      <= '0;
            shreg        <= '0;
            par          <= 1'b0;
            tcnt         <= '0;
            scan_code    <= 8'h00;
            scan_valid   <= 1'b0;
            key_released <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            data_s1      <= ps2_data;
            data_s       <= data_s1;
            fstate       <= fstate_n;
            dstate       <= dstate_n;
            bit_cnt      <= bit_cnt_n;
            shreg        <= shreg_n;
            par          <= par_n;
            tcnt         <= tcnt_n;
            scan_code    <= code_n;
            scan_valid   <= sv_n;
            key_released <= kr_n;
            frame_err    <= err_n;
        end
    end
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: directed and random PS/2 frames checked against a byte-level key model.
`timescale 1ns/1ps
module tb_ps2_scan_receiver;
    localparam int CLKP = 500;
    localparam int H    = 40000;
    localparam int TO   = 1000;

    logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic scan_valid, key_released, frame_err;
    int compared = 0, failed = 0;
    int n_sv = 0, n_kr = 0, n_err = 0, n_ovl = 0;
    logic [7:0] m_code = 8'h00;
    bit m_ext = 0, m_brk = 0;

    ps2_scan_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .key_released(key_released),
        .frame_err   (frame_err)
    );

    always #(CLKP/2) clk = ~clk;

    always @(negedge clk) if (rst_n) begin
        n_sv  += int'(scan_valid);
        n_kr  += int'(key_released);
        n_err += int'(frame_err);
        if ((scan_valid && key_released) || (frame_err && (scan_valid || key_released))) n_ovl++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Key model: make/break/extended rules applied to whole received bytes.
    task automatic model(input logic [7:0] b, input int kind, output int esv, output int ekr, output int eer);
        esv = 0; ekr = 0; eer = 0;
        if (kind != 0) begin
            eer = 1; m_ext = 0; m_brk = 0;
        end else if (m_ext) begin
            if (!m_brk && b == 8'hF0) m_brk = 1;
            else begin m_ext = 0; m_brk = 0; end
        end else if (m_brk) begin
            if (b == m_code) begin m_code = 8'h00; ekr = 1; end
            m_brk = 0;
        end else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin m_code = b; esv = 1; end
    endtask

    // kind: 0 good, 1 bad parity, 2 stop bit low
    task automatic send_bits(input logic [7:0] b, input int kind, input bit glitch, input int nbits);
        logic [10:0] fr;
        fr = {kind != 2, (~^b) ^ (kind == 1), b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            #(H/2) ps2_data = fr[i];
            if (glitch && i == 4) begin
                ps2_clk = 1'b0; #(3*CLKP) ps2_clk = 1'b1; #(H/2 - 3*CLKP);
            end else #(H/2);
            ps2_clk = 1'b0;
            if (glitch && i == 6) begin
                #(H/2) ps2_clk = 1'b1; #(3*CLKP) ps2_clk = 1'b0; #(H/2 - 3*CLKP);
            end else #(H);
            ps2_clk = 1'b1;
        end
        #(H/2) ps2_data = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input int kind, input bit glitch, input string tag);
        int sv0, kr0, er0, esv, ekr, eer;
        sv0 = n_sv; kr0 = n_kr; er0 = n_err;
        model(b, kind, esv, ekr, eer);
        send_bits(b, kind, glitch, 11);
        #(H);
        chk({tag, " scan_code"}, 32'(scan_code), 32'(m_code));
        chk({tag, " scan_valid"}, n_sv - sv0, esv);
        chk({tag, " key_released"}, n_kr - kr0, ekr);
        chk({tag, " frame_err"}, n_err - er0, eer);
    endtask

    initial begin
        int er0, sv0, r, kind;
        logic [7:0] b;
        #(3*CLKP);
        chk("reset scan_code", 32'(scan_code), 0);
        chk("reset scan_valid", 32'(scan_valid), 0);
        chk("reset key_released", 32'(key_released), 0);
        chk("reset frame_err", 32'(frame_err), 0);
        rst_n = 1'b1;
        #(5*CLKP);
        frame(8'h1C, 0, 0, "make 1C");
        frame(8'hF0, 0, 0, "F0 before 1C");
        frame(8'h1C, 0, 0, "break 1C");
        frame(8'h16, 0, 0, "make 16");
        frame(8'h1E, 0, 0, "make 1E");
        frame(8'hF0, 0, 0, "F0 before 16");
        frame(8'h16, 0, 0, "break 16 other");
        frame(8'h45, 1, 0, "45 bad parity");
        frame(8'h45, 2, 0, "45 bad stop");
        frame(8'h45, 0, 0, "good 45");
        frame(8'hF0, 0, 0, "F0 before 45");
        frame(8'h45, 0, 0, "break 45");
        frame(8'hE0, 0, 0, "E0 a");
        frame(8'h75, 0, 0, "ext make 75");
        frame(8'hE0, 0, 0, "E0 b");
        frame(8'hF0, 0, 0, "ext F0");
        frame(8'h75, 0, 0, "ext break 75");
        frame(8'h5A, 0, 0, "make 5A");
        er0 = n_err; sv0 = n_sv;
        send_bits(8'h33, 0, 0, 5);
        #((TO + 300) * CLKP);
        m_ext = 0; m_brk = 0;
        chk("timeout frame_err", n_err - er0, 1);
        chk("timeout scan_valid", n_sv - sv0, 0);
        chk("timeout scan_code", 32'(scan_code), 32'(m_code));
        frame(8'h2D, 0, 0, "after timeout 2D");
        frame(8'h3C, 0, 1, "glitched 3C");
        send_bits(8'h4B, 0, 0, 4);
        rst_n = 1'b0;
        #1;
        chk("midframe reset scan_code", 32'(scan_code), 0);
        chk("midframe reset scan_valid", 32'(scan_valid), 0);
        #(5*CLKP) rst_n = 1'b1;
        m_code = 8'h00; m_ext = 0; m_brk = 0;
        #(H);
        frame(8'h29, 0, 0, "after reset 29");
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, 9);
            b = r < 2 ? 8'hF0 : r == 2 ? 8'hE0 : (r == 3 && m_code != 0) ? m_code : 8'($urandom_range(1, 127));
            kind = $urandom_range(0, 7) == 0 ? $urandom_range(1, 2) : 0;
            frame(b, kind, 0, $sformatf("random %0d byte %0h", i, b));
        end
        chk("pulse overlap", n_ovl, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
